pokey_kbd_scan: RTL and testbench

- Keyboard scanner stage directly upstream of the POKEY IRQ core.
- Drives the 6-bit keyboard scan lines and samples the active-low KR1/KR2 return lines.
- Debounces key presses, latches KBCODE, and produces the one-cycle setKey/setBreak strobes the IRQ core consumes.
- Also provides the SKSTAT key-down and shift status bits.

---
 rtl/pokey_kbd_scan_pkg.sv | 21 ++
 rtl/pokey_kbd_cnt.sv | 38 +++
 rtl/pokey_kbd_scan.sv | 154 +++++++++++++++
 tb/tb_pokey_kbd_scan.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pokey_kbd_scan_pkg.sv
// Shared definitions for the POKEY keyboard scanner.
//   - kbd_state_e : scanner debounce FSM states
//   - SKSTAT_*    : bit positions of the scanner status bits inside SKSTAT
//   - DEF_*_CODE  : scan counts at which KR2 reflects SHIFT / CONTROL / BREAK
package pokey_kbd_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DOWN = 2'd2,
    ST_REL  = 2'd3
  } kbd_state_e;

  localparam int SKSTAT_KEYDOWN_BIT = 2;
  localparam int SKSTAT_SHIFT_BIT   = 3;

  localparam logic [5:0] DEF_SHIFT_CODE = 6'h30;
  localparam logic [5:0] DEF_CTRL_CODE  = 6'h20;
  localparam logic [5:0] DEF_BREAK_CODE = 6'h10;

endpackage

// File: rtl/pokey_kbd_cnt.sv
// 6-bit keyboard scan counter.
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active high
//   scan_tick_i one-clk scan step strobe
//   kb_en_i     keyboard scan enable; low holds the counter at 0
//   cnt_o       current scan count (wraps 63 -> 0)
module pokey_kbd_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick_i,
  input  logic       kb_en_i,
  output logic [5:0] cnt_o
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!kb_en_i) begin
      cnt_d = 6'd0;
    end else if (scan_tick_i) begin
      cnt_d = cnt_q + 6'd1;   // natural 6-bit wrap
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pokey_kbd_scan.sv
// POKEY keyboard scanner: drives the scan lines, samples the active-low
// KR1/KR2 returns, debounces key presses, latches KBCODE and produces the
// setKey/setBreak strobes for the IRQ core plus the SKSTAT key/shift bits.
// Ports:
//   clk, rst         system clock, async active-high reset
//   scanTick         one-clk scan step strobe
//   kbEn, debEn      SKCTL keyboard scan enable / debounce enable
//   nkr1, nkr2       active-low key / modifier return lines (synchronised)
//   kOut             scan count to the keyboard matrix
//   kbcode           {ctrl, shift, key code}
//   setKey, setBreak one-clk event strobes
//   keyDown          debounced key held
//   shiftDown        current SHIFT state
//
// state | meaning
// IDLE  | no key tracked; first low KR1 captures its scan count
// PEND  | candidate key seen once; confirm on the next pass over it
// DOWN  | key latched and held
// REL   | key seen released once; confirm release on the next pass
module pokey_kbd_scan
  import pokey_kbd_scan_pkg::*;
#(
  parameter logic [5:0] SHIFT_CODE = DEF_SHIFT_CODE,
  parameter logic [5:0] CTRL_CODE  = DEF_CTRL_CODE,
  parameter logic [5:0] BREAK_CODE = DEF_BREAK_CODE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scanTick,
  input  logic       kbEn,
  input  logic       debEn,
  input  logic       nkr1,
  input  logic       nkr2,
  output logic [5:0] kOut,
  output logic [7:0] kbcode,
  output logic       setKey,
  output logic       setBreak,
  output logic       keyDown,
  output logic       shiftDown
);

  logic [5:0] cnt;
  logic [5:0] cmp_q;
  kbd_state_e state_q;
  logic [7:0] kbcode_q;
  logic       set_key_q;
  logic       set_break_q;
  logic       key_down_q;
  logic       shift_q;
  logic       ctrl_q;
  logic       break_prev_q;
  logic       hit;

  pokey_kbd_cnt u_cnt (
    .clk         (clk),
    .rst         (rst),
    .scan_tick_i (scanTick),
    .kb_en_i     (kbEn),
    .cnt_o       (cnt)
  );

  // A hit is a pass over the scan count captured when the key was first seen;
  // every other scan step is ignored while tracking, which rejects rollover.
  assign hit = (cnt == cmp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q        <= 6'd0;
      state_q      <= ST_IDLE;
      kbcode_q     <= 8'h00;
      set_key_q    <= 1'b0;
      set_break_q  <= 1'b0;
      key_down_q   <= 1'b0;
      shift_q      <= 1'b0;
      ctrl_q       <= 1'b0;
      break_prev_q <= 1'b0;
    end else begin
      set_key_q   <= 1'b0;
      set_break_q <= 1'b0;
      if (!kbEn) begin
        // kbcode deliberately holds its last value
        state_q      <= ST_IDLE;
        key_down_q   <= 1'b0;
        shift_q      <= 1'b0;
        ctrl_q       <= 1'b0;
        break_prev_q <= 1'b0;
      end else if (scanTick) begin
        if (cnt == SHIFT_CODE) shift_q <= ~nkr2;
        if (cnt == CTRL_CODE)  ctrl_q  <= ~nkr2;
        if (cnt == BREAK_CODE) begin
          set_break_q  <= ~nkr2 & ~break_prev_q;
          break_prev_q <= ~nkr2;
        end

        unique case (state_q)
          ST_IDLE: begin
            if (!nkr1) begin
              cmp_q <= cnt;
              if (debEn) begin
                state_q <= ST_PEND;
              end else begin
                state_q    <= ST_DOWN;
                kbcode_q   <= {ctrl_q, shift_q, cnt};
                set_key_q  <= 1'b1;
                key_down_q <= 1'b1;
              end
            end
          end
          ST_PEND: begin
            if (hit) begin
              if (!nkr1) begin
                state_q    <= ST_DOWN;
                kbcode_q   <= {ctrl_q, shift_q, cnt};
                set_key_q  <= 1'b1;
                key_down_q <= 1'b1;
              end else begin
                state_q    <= ST_IDLE;
                key_down_q <= 1'b0;
              end
            end
          end
          ST_DOWN: begin
            if (hit && nkr1) begin
              if (debEn) begin
                state_q <= ST_REL;
              end else begin
                state_q    <= ST_IDLE;
                key_down_q <= 1'b0;
              end
            end
          end
          ST_REL: begin
            if (hit) begin
              if (nkr1) begin
                state_q    <= ST_IDLE;
                key_down_q <= 1'b0;
              end else begin
                state_q <= ST_DOWN;
              end
            end
          end
        endcase
      end
    end
  end

  assign kOut      = cnt;
  assign kbcode    = kbcode_q;
  assign setKey    = set_key_q;
  assign setBreak  = set_break_q;
  assign keyDown   = key_down_q;
  assign shiftDown = shift_q;

endmodule

// File: tb/tb_pokey_kbd_scan.sv
module tb_pokey_kbd_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       scanTick;
  logic       kbEn;
  logic       debEn;
  logic       nkr1;
  logic       nkr2;
  logic [5:0] kOut;
  logic [7:0] kbcode;
  logic       setKey;
  logic       setBreak;
  logic       keyDown;
  logic       shiftDown;

  int n_cmp = 0;
  int n_bad = 0;

  // keyboard matrix model: bit n set = key / modifier at scan count n pressed
  logic [63:0] key_mask;
  logic [63:0] mod_mask;
  logic [5:0]  tick_cnt;

  // scoreboard: expected kbcode per setKey, one entry per expected setBreak
  logic [7:0] exp_key_q[$];
  int         exp_brk_q[$];
  logic [7:0] mon_e;
  int         mon_b;

  always #5 clk = ~clk;

  pokey_kbd_scan dut (
    .clk       (clk),
    .rst       (rst),
    .scanTick  (scanTick),
    .kbEn      (kbEn),
    .debEn     (debEn),
    .nkr1      (nkr1),
    .nkr2      (nkr2),
    .kOut      (kOut),
    .kbcode    (kbcode),
    .setKey    (setKey),
    .setBreak  (setBreak),
    .keyDown   (keyDown),
    .shiftDown (shiftDown)
  );

  always @(posedge clk) begin
    #1;
    if (rst === 1'b0) begin
      if (setKey === 1'b1) begin
        n_cmp++;
        if (exp_key_q.size() == 0) begin
          n_bad++;
          $display("FAIL setKey_unexpected: got pulse kbcode=%h, required no pulse", kbcode);
        end else begin
          mon_e = exp_key_q.pop_front();
          if (kbcode !== mon_e) begin
            n_bad++;
            $display("FAIL setKey_kbcode: got %h, required %h", kbcode, mon_e);
          end
        end
      end
      if (setBreak === 1'b1) begin
        n_cmp++;
        if (exp_brk_q.size() == 0) begin
          n_bad++;
          $display("FAIL setBreak_unexpected: got pulse, required no pulse");
        end else begin
          mon_b = exp_brk_q.pop_front();
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    tick_cnt = kOut;
    nkr1 = ~key_mask[kOut];
    nkr2 = ~mod_mask[kOut];
    scanTick = 1'b1;
    @(posedge clk);
    #1;
    scanTick = 1'b0;
    nkr1 = 1'b1;
    nkr2 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scanTick = 1'b0;
    nkr1 = 1'b1;
    nkr2 = 1'b1;
    key_mask = '0;
    mod_mask = '0;
    exp_key_q.delete();
    exp_brk_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    kbEn = 1'b1;
    debEn = 1'b1;
    do_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({kOut, kbcode, setKey, setBreak, keyDown, shiftDown} !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {kOut, kbcode, setKey, setBreak, keyDown, shiftDown});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    do_reset();
    kbEn = 1'b1;
    debEn = 1'b1;
    key_mask[6'h15] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 64; i++) begin
        if (r == 1 && kOut == 6'h15) exp_key_q.push_back(8'h15);
        step();
        n_cmp++;
        if (tick_cnt !== i[5:0]) begin
          n_bad++;
          $display("FAIL scan_count: got %h, required %h", tick_cnt, i[5:0]);
        end
        if (r == 1 && tick_cnt == 6'h15) begin
          n_cmp++;
          if (setKey !== 1'b1) begin
            n_bad++;
            $display("FAIL debounce_setKey: got %b, required 1", setKey);
          end
        end
      end
      if (r == 0) begin
        n_cmp++;
        if (keyDown !== 1'b0) begin
          n_bad++;
          $display("FAIL debounce_pend_keyDown: got %b, required 0", keyDown);
        end
      end
    end
    n_cmp++;
    if (kbcode !== 8'h15 || keyDown !== 1'b1) begin
      n_bad++;
      $display("FAIL debounce_final: got kbcode=%h keyDown=%b, required 15/1", kbcode, keyDown);
    end
    n_cmp++;
    if (exp_key_q.size() != 0) begin
      n_bad++;
      $display("FAIL debounce_missing: got %0d unmatched, required 0", exp_key_q.size());
    end
  endtask

  task automatic test_bounce();
    do_reset();
    kbEn = 1'b1;
    debEn = 1'b1;
    for (int r = 0; r < 3; r++) begin
      key_mask[6'h15] = (r != 1);
      for (int i = 0; i < 64; i++) begin
        step();
        n_cmp++;
        if (keyDown !== 1'b0) begin
          n_bad++;
          $display("FAIL bounce_keyDown: got %b, required 0 (round %0d cnt %h)", keyDown, r, tick_cnt);
        end
      end
    end
  endtask

  task automatic test_shift_ctrl();
    do_reset();
    kbEn = 1'b1;
    debEn = 1'b0;
    mod_mask[6'h30] = 1'b1;
    mod_mask[6'h20] = 1'b1;
    key_mask[6'h3F] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (kOut == 6'h3F) exp_key_q.push_back(8'hFF);
      step();
      if (tick_cnt == 6'h3F) begin
        n_cmp++;
        if (setKey !== 1'b1 || kbcode !== 8'hFF) begin
          n_bad++;
          $display("FAIL shift_ctrl_latch: got setKey=%b kbcode=%h, required 1/FF", setKey, kbcode);
        end
      end
    end
    n_cmp++;
    if (shiftDown !== 1'b1 || keyDown !== 1'b1) begin
      n_bad++;
      $display("FAIL shift_ctrl_status: got shiftDown=%b keyDown=%b, required 1/1", shiftDown, keyDown);
    end
    n_cmp++;
    if (exp_key_q.size() != 0) begin
      n_bad++;
      $display("FAIL shift_ctrl_missing: got %0d unmatched, required 0", exp_key_q.size());
    end
  endtask

  task automatic test_rollover();
    do_reset();
    kbEn = 1'b1;
    debEn = 1'b1;
    key_mask[6'h22] = 1'b1;
    for (int r = 0; r < 5; r++) begin
      key_mask[6'h15] = (r < 3);
      for (int i = 0; i < 64; i++) begin
        if (r == 1 && kOut == 6'h15) exp_key_q.push_back(8'h15);
        step();
        if (r == 3 && tick_cnt == 6'h15) begin
          n_cmp++;
          if (keyDown !== 1'b1) begin
            n_bad++;
            $display("FAIL rollover_rel_keyDown: got %b, required 1", keyDown);
          end
        end
        if (r == 4 && tick_cnt == 6'h14) begin
          n_cmp++;
          if (keyDown !== 1'b1) begin
            n_bad++;
            $display("FAIL rollover_pre_release: got %b, required 1", keyDown);
          end
        end
        if (r == 4 && tick_cnt == 6'h15) begin
          n_cmp++;
          if (keyDown !== 1'b0) begin
            n_bad++;
            $display("FAIL rollover_release: got %b, required 0", keyDown);
          end
        end
      end
    end
    n_cmp++;
    if (exp_key_q.size() != 0) begin
      n_bad++;
      $display("FAIL rollover_missing: got %0d unmatched, required 0", exp_key_q.size());
    end
  endtask

  task automatic test_break();
    do_reset();
    kbEn = 1'b1;
    debEn = 1'b1;
    for (int r = 0; r < 5; r++) begin
      mod_mask[6'h10] = (r != 3);
      for (int i = 0; i < 64; i++) begin
        if ((r == 0 || r == 4) && kOut == 6'h10) exp_brk_q.push_back(1);
        step();
        if (tick_cnt == 6'h10) begin
          n_cmp++;
          if (setBreak !== ((r == 0 || r == 4) ? 1'b1 : 1'b0)) begin
            n_bad++;
            $display("FAIL break_pulse: got %b in round %0d, required %b",
                     setBreak, r, (r == 0 || r == 4));
          end
        end
      end
    end
    n_cmp++;
    if (exp_brk_q.size() != 0) begin
      n_bad++;
      $display("FAIL break_missing: got %0d unmatched, required 0", exp_brk_q.size());
    end
  endtask

  task automatic test_kben_drop_rst();
    do_reset();
    kbEn = 1'b1;
    debEn = 1'b0;
    key_mask[6'h15] = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (kOut == 6'h15) exp_key_q.push_back(8'h15);
      step();
    end
    @(negedge clk);
    kbEn = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (kOut !== 6'd0 || keyDown !== 1'b0 || kbcode !== 8'h15) begin
      n_bad++;
      $display("FAIL kben_drop: got kOut=%h keyDown=%b kbcode=%h, required 00/0/15",
               kOut, keyDown, kbcode);
    end
    key_mask = '0;
    key_mask[6'h00] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (kOut !== 6'd0 || keyDown !== 1'b0) begin
        n_bad++;
        $display("FAIL kben_off_hold: got kOut=%h keyDown=%b, required 00/0", kOut, keyDown);
      end
    end
    key_mask = '0;
    key_mask[6'h35] = 1'b1;
    mod_mask[6'h30] = 1'b1;
    @(negedge clk);
    kbEn = 1'b1;
    for (int i = 0; i < 54; i++) begin
      if (kOut == 6'h35) exp_key_q.push_back(8'h75);
      step();
    end
    n_cmp++;
    if (setKey !== 1'b1 || shiftDown !== 1'b1 || kbcode !== 8'h75) begin
      n_bad++;
      $display("FAIL rekey_latch: got setKey=%b shiftDown=%b kbcode=%h, required 1/1/75",
               setKey, shiftDown, kbcode);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({kOut, kbcode, setKey, setBreak, keyDown, shiftDown} !== 18'h0) begin
      n_bad++;
      $display("FAIL async_rst: got %h, required 0",
               {kOut, kbcode, setKey, setBreak, keyDown, shiftDown});
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (exp_key_q.size() != 0) begin
      n_bad++;
      $display("FAIL kben_missing: got %0d unmatched, required 0", exp_key_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    scanTick = 1'b0;
    kbEn = 1'b1;
    debEn = 1'b1;
    nkr1 = 1'b1;
    nkr2 = 1'b1;
    key_mask = '0;
    mod_mask = '0;
    tick_cnt = '0;
    test_reset();
    test_debounce();
    test_bounce();
    test_shift_ctrl();
    test_rollover();
    test_break();
    test_kben_drop_rst();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
